// File: rtl/shk_chose_n_pkg.sv
// Shared definitions for the registered shake-bus chooser: FSM encodings,
// the error return pattern and a constant-evaluable clog2.
package shk_chose_n_pkg;

    localparam logic [1:0] SHK_IDLE = 2'd0;
    localparam logic [1:0] SHK_SEND = 2'd1;
    localparam logic [1:0] SHK_RESP = 2'd2;
    localparam logic [1:0] SHK_DROP = 2'd3;

    // Wide enough for any sync bus; users slice the low WD_SHK_SYNC bits.
    localparam logic [63:0] SHK_ERR_SMISO = {64{1'b1}};

    function automatic int shk_clog2(input int val);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < val) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shk_chose_n_sel_enc.sv
// Lowest-set-bit priority encoder used to pick the downstream channel.
module shk_sel_enc #(
    parameter int NB_CHN = 8,
    parameter int WD_IDX = 3
) (
    input  logic [NB_CHN-1:0] sel_i,
    output logic [WD_IDX-1:0] idx_o,
    output logic              vld_o
);

    logic [WD_IDX-1:0] idx_s;
    logic              vld_s;

    // Scan upwards and keep only the first set bit.
    always_comb begin
        idx_s = {WD_IDX{1'b0}};
        vld_s = 1'b0;
        for (int i = 0; i < NB_CHN; i++) begin
            if (sel_i[i] && !vld_s) begin
                idx_s = WD_IDX'(i);
                vld_s = 1'b1;
            end else begin
                vld_s = vld_s;
            end
        end
    end

    assign idx_o = idx_s;
    assign vld_o = vld_s;

endmodule

// File: rtl/shk_chose_n.sv
// Registered 1-to-NB_CHN shake chooser: one transaction at a time, routed to
// the lowest selected channel, guarded by a timeout, closed by a wready pulse.
module shk_chose_n
    import shk_chose_n_pkg::*;
#(
    parameter int NB_CHN      = 8,
    parameter int WD_SHK_SYNC = 16,
    parameter int WD_SHK_DLAY = 15,
    parameter int NB_TMOUT    = 1024,
    parameter int WD_TMOUT    = 11,
    parameter int WD_ERR_CNT  = 8
) (
    input  logic                          i_sys_clk,
    input  logic                          i_sys_rst,
    input  logic                          s_shk_wvalid,
    input  logic [WD_SHK_SYNC-1:0]        s_shk_smosi,
    input  logic [WD_SHK_DLAY-1:0]        s_shk_dmosi,
    output logic                          s_shk_wready,
    output logic [WD_SHK_SYNC-1:0]        s_shk_smiso,
    output logic [WD_SHK_DLAY-1:0]        s_shk_dmiso,
    output logic [NB_CHN-1:0]             m_shk_wvalid,
    output logic [NB_CHN*WD_SHK_SYNC-1:0] m_shk_smosi,
    output logic [NB_CHN*WD_SHK_DLAY-1:0] m_shk_dmosi,
    input  logic [NB_CHN-1:0]             m_shk_wready,
    input  logic [NB_CHN*WD_SHK_SYNC-1:0] m_shk_smiso,
    input  logic [NB_CHN*WD_SHK_DLAY-1:0] m_shk_dmiso,
    output logic                          o_shk_err,
    output logic [WD_ERR_CNT-1:0]         o_err_cnt
);

    localparam int WD_IDX_RAW = shk_clog2(NB_CHN);
    localparam int WD_IDX     = (WD_IDX_RAW < 1) ? 1 : WD_IDX_RAW;

    localparam logic [WD_TMOUT-1:0]   TMO_LAST = WD_TMOUT'(NB_TMOUT - 1);
    localparam logic [WD_ERR_CNT-1:0] ERR_MAX  = {WD_ERR_CNT{1'b1}};
    localparam logic [NB_CHN-1:0]     CHN_ONE  = NB_CHN'(1'b1);

    logic [1:0]             state_q,     state_d;
    logic [WD_IDX-1:0]      sel_q,       sel_d;
    logic [WD_SHK_SYNC-1:0] smosi_q,     smosi_d;
    logic [WD_SHK_DLAY-1:0] dmosi_q,     dmosi_d;
    logic [WD_TMOUT-1:0]    tmo_q,       tmo_d;
    logic [NB_CHN-1:0]      m_wvalid_q,  m_wvalid_d;
    logic                   s_wready_q,  s_wready_d;
    logic [WD_SHK_SYNC-1:0] s_smiso_q,   s_smiso_d;
    logic [WD_SHK_DLAY-1:0] s_dmiso_q,   s_dmiso_d;
    logic                   err_q,       err_d;
    logic [WD_ERR_CNT-1:0]  err_cnt_q,   err_cnt_d;

    logic [WD_IDX-1:0]      enc_idx_s;
    logic                   enc_vld_s;
    logic                   fail_s;
    logic                   sel_rdy_s;
    logic [WD_SHK_SYNC-1:0] sel_smiso_s;
    logic [WD_SHK_DLAY-1:0] sel_dmiso_s;

    shk_sel_enc #(
        .NB_CHN (NB_CHN),
        .WD_IDX (WD_IDX)
    ) u_sel_enc (
        .sel_i (s_shk_smosi[NB_CHN-1:0]),
        .idx_o (enc_idx_s),
        .vld_o (enc_vld_s)
    );

    assign sel_rdy_s   = m_shk_wready[sel_q];
    assign sel_smiso_s = m_shk_smiso[int'(sel_q)*WD_SHK_SYNC +: WD_SHK_SYNC];
    assign sel_dmiso_s = m_shk_dmiso[int'(sel_q)*WD_SHK_DLAY +: WD_SHK_DLAY];

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        smosi_d    = smosi_q;
        dmosi_d    = dmosi_q;
        tmo_d      = tmo_q;
        m_wvalid_d = m_wvalid_q;
        s_wready_d = 1'b0;
        s_smiso_d  = s_smiso_q;
        s_dmiso_d  = s_dmiso_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        fail_s     = 1'b0;
        case (state_q)
            SHK_IDLE: begin
                if (s_shk_wvalid) begin
                    smosi_d = s_shk_smosi;
                    dmosi_d = s_shk_dmosi;
                    sel_d   = enc_idx_s;
                    tmo_d   = {WD_TMOUT{1'b0}};
                    if (enc_vld_s) begin
                        state_d    = SHK_SEND;
                        m_wvalid_d = CHN_ONE << enc_idx_s;
                    end else begin
                        state_d = SHK_RESP;
                        fail_s  = 1'b1;
                    end
                end else begin
                    m_wvalid_d = {NB_CHN{1'b0}};
                end
            end
            SHK_SEND: begin
                // Ready is tested first so it wins over a coincident timeout.
                if (sel_rdy_s) begin
                    state_d    = SHK_RESP;
                    m_wvalid_d = {NB_CHN{1'b0}};
                    s_wready_d = 1'b1;
                    s_smiso_d  = sel_smiso_s;
                    s_dmiso_d  = sel_dmiso_s;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = SHK_RESP;
                    m_wvalid_d = {NB_CHN{1'b0}};
                    fail_s     = 1'b1;
                end else begin
                    tmo_d = tmo_q + WD_TMOUT'(1'b1);
                end
            end
            SHK_RESP: begin
                state_d    = SHK_DROP;
                m_wvalid_d = {NB_CHN{1'b0}};
            end
            SHK_DROP: begin
                m_wvalid_d = {NB_CHN{1'b0}};
                if (!s_shk_wvalid) begin
                    state_d = SHK_IDLE;
                end else begin
                    state_d = SHK_DROP;
                end
            end
            default: begin
                state_d    = SHK_IDLE;
                m_wvalid_d = {NB_CHN{1'b0}};
            end
        endcase

        if (fail_s) begin
            s_wready_d = 1'b1;
            s_smiso_d  = SHK_ERR_SMISO[WD_SHK_SYNC-1:0];
            s_dmiso_d  = {WD_SHK_DLAY{1'b0}};
            err_d      = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + WD_ERR_CNT'(1'b1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_cnt_d = err_cnt_d;
        end
    end

    // State and output registers; reset drops every valid at once.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q    <= SHK_IDLE;
            sel_q      <= {WD_IDX{1'b0}};
            smosi_q    <= {WD_SHK_SYNC{1'b0}};
            dmosi_q    <= {WD_SHK_DLAY{1'b0}};
            tmo_q      <= {WD_TMOUT{1'b0}};
            m_wvalid_q <= {NB_CHN{1'b0}};
            s_wready_q <= 1'b0;
            s_smiso_q  <= {WD_SHK_SYNC{1'b0}};
            s_dmiso_q  <= {WD_SHK_DLAY{1'b0}};
            err_q      <= 1'b0;
            err_cnt_q  <= {WD_ERR_CNT{1'b0}};
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            smosi_q    <= smosi_d;
            dmosi_q    <= dmosi_d;
            tmo_q      <= tmo_d;
            m_wvalid_q <= m_wvalid_d;
            s_wready_q <= s_wready_d;
            s_smiso_q  <= s_smiso_d;
            s_dmiso_q  <= s_dmiso_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign s_shk_wready = s_wready_q;
    assign s_shk_smiso  = s_smiso_q;
    assign s_shk_dmiso  = s_dmiso_q;
    assign m_shk_wvalid = m_wvalid_q;
    assign m_shk_smosi  = {NB_CHN{smosi_q}};
    assign m_shk_dmosi  = {NB_CHN{dmosi_q}};
    assign o_shk_err    = err_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_shk_chose_n.sv
// Bench for shk_chose_n: table vectors, random transactions against a
// transaction-level model, and hand sequences for held request and reset.
module tb_shk_chose_n;

    localparam int NB  = 8;
    localparam int WS  = 16;
    localparam int WDL = 15;
    localparam int TMO = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_shk_wvalid = 1'b0;
    logic [WS-1:0]      s_shk_smosi  = '0;
    logic [WDL-1:0]     s_shk_dmosi  = '0;
    logic               s_shk_wready;
    logic [WS-1:0]      s_shk_smiso;
    logic [WDL-1:0]     s_shk_dmiso;
    logic [NB-1:0]      m_shk_wvalid;
    logic [NB*WS-1:0]   m_shk_smosi;
    logic [NB*WDL-1:0]  m_shk_dmosi;
    logic [NB-1:0]      m_shk_wready = '0;
    logic [NB*WS-1:0]   m_shk_smiso  = '0;
    logic [NB*WDL-1:0]  m_shk_dmiso  = '0;
    logic               o_shk_err;
    logic [7:0]         o_err_cnt;

    int total = 0;
    int bad   = 0;
    int err_model = 0;

    shk_chose_n #(
        .NB_CHN(NB), .WD_SHK_SYNC(WS), .WD_SHK_DLAY(WDL),
        .NB_TMOUT(TMO), .WD_TMOUT(5), .WD_ERR_CNT(8)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .s_shk_wvalid(s_shk_wvalid), .s_shk_smosi(s_shk_smosi), .s_shk_dmosi(s_shk_dmosi),
        .s_shk_wready(s_shk_wready), .s_shk_smiso(s_shk_smiso), .s_shk_dmiso(s_shk_dmiso),
        .m_shk_wvalid(m_shk_wvalid), .m_shk_smosi(m_shk_smosi), .m_shk_dmosi(m_shk_dmosi),
        .m_shk_wready(m_shk_wready), .m_shk_smiso(m_shk_smiso), .m_shk_dmiso(m_shk_dmiso),
        .o_shk_err(o_shk_err), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] smosi;
        logic [14:0] dmosi;
        int          delay;
        logic [15:0] r_smiso;
        logic [14:0] r_dmiso;
        bit          noise;
        logic [7:0]  e_wv;
        int          e_resp;
        logic [15:0] e_smiso;
        logic [14:0] e_dmiso;
        bit          e_err;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: lowest selected channel, answered in time or timed out.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int ch;
        r  = v;
        ch = -1;
        for (int i = 0; i < NB; i++) if (ch < 0 && v.smosi[i]) ch = i;
        if (ch < 0) begin
            r.e_wv = 8'h00; r.e_resp = 1; r.e_err = 1'b1;
        end else if (v.delay < TMO) begin
            r.e_wv = 8'(1 << ch); r.e_resp = v.delay + 2; r.e_err = 1'b0;
        end else begin
            r.e_wv = 8'(1 << ch); r.e_resp = TMO + 1; r.e_err = 1'b1;
        end
        r.e_smiso = r.e_err ? 16'hFFFF : v.r_smiso;
        r.e_dmiso = r.e_err ? 15'h0000 : v.r_dmiso;
        return r;
    endfunction

    // One full transaction with per-channel slave responders reacting to m_shk_wvalid.
    task automatic run_txn(input vec_t v, input string nm);
        int rc;
        logic [7:0]  wv1;
        logic [127:0] sm1;
        logic [119:0] dm1;
        logic [15:0] smiso;
        logic [14:0] dmiso;
        logic        err;
        logic [7:0]  ecnt;
        rc = -1; wv1 = '0; sm1 = '0; dm1 = '0; smiso = '0; dmiso = '0; err = 1'b0; ecnt = '0;
        s_shk_wvalid = 1'b1;
        s_shk_smosi  = v.smosi;
        s_shk_dmosi  = v.dmosi;
        m_shk_wready = '0;
        for (int cyc = 1; cyc <= 40 && rc < 0; cyc++) begin
            tick();
            if (cyc == 1) begin
                wv1 = m_shk_wvalid; sm1 = m_shk_smosi; dm1 = m_shk_dmosi;
            end
            if (s_shk_wready) begin
                rc = cyc; smiso = s_shk_smiso; dmiso = s_shk_dmiso;
                err = o_shk_err; ecnt = o_err_cnt;
            end else begin
                m_shk_wready = ((cyc == 1 + v.delay) ? m_shk_wvalid : 8'h00)
                             | (v.noise ? ~m_shk_wvalid : 8'h00);
                for (int k = 0; k < NB; k++) begin
                    m_shk_smiso[k*WS +: WS]   = m_shk_wvalid[k] ? v.r_smiso : ~v.r_smiso;
                    m_shk_dmiso[k*WDL +: WDL] = m_shk_wvalid[k] ? v.r_dmiso : ~v.r_dmiso;
                end
            end
        end
        if (v.e_err) err_model = (err_model < 255) ? err_model + 1 : 255;
        s_shk_wvalid = 1'b0;
        m_shk_wready = '0;
        chk({nm, "_wvalid"}, wv1, v.e_wv);
        chk({nm, "_smosi"}, sm1, {NB{v.smosi}});
        chk({nm, "_dmosi"}, dm1, {NB{v.dmosi}});
        chk({nm, "_resp_cycle"}, rc, v.e_resp);
        chk({nm, "_smiso"}, smiso, v.e_smiso);
        chk({nm, "_dmiso"}, dmiso, v.e_dmiso);
        chk({nm, "_err"}, err, v.e_err);
        chk({nm, "_err_cnt"}, ecnt, err_model[7:0]);
        tick();
        chk({nm, "_pulse_end"}, {s_shk_wready, o_shk_err, m_shk_wvalid}, 10'h000);
        tick();
    endtask

    vec_t tbl [8];
    vec_t v;
    int   nreq, nresp;
    logic prev;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        //             smosi     dmosi     dly  r_smiso   r_dmiso  nz  e_wv   rsp  e_smiso   e_dmiso   err
        tbl[0] = '{16'h0004, 15'h1234,  3, 16'hA5A5, 15'h0ABC, 0, 8'h04,  5, 16'hA5A5, 15'h0ABC, 0};
        tbl[1] = '{16'h0012, 15'h0055,  3, 16'h1111, 15'h0222, 1, 8'h02,  5, 16'h1111, 15'h0222, 0};
        tbl[2] = '{16'h0100, 15'h0777,  0, 16'h2222, 15'h0333, 0, 8'h00,  1, 16'hFFFF, 15'h0000, 1};
        tbl[3] = '{16'h0080, 15'h7FFF, 15, 16'h7E7E, 15'h7FFF, 0, 8'h80, 17, 16'h7E7E, 15'h7FFF, 0};
        tbl[4] = '{16'h0001, 15'h0001, 16, 16'h3333, 15'h0444, 0, 8'h01, 17, 16'hFFFF, 15'h0000, 1};
        tbl[5] = '{16'h0040, 15'h0F0F, 16, 16'h4444, 15'h0555, 1, 8'h40, 17, 16'hFFFF, 15'h0000, 1};
        tbl[6] = '{16'hFFFF, 15'h0000,  0, 16'hC3C3, 15'h1F1F, 1, 8'h01,  2, 16'hC3C3, 15'h1F1F, 0};
        tbl[7] = '{16'h8200, 15'h1010,  1, 16'h5555, 15'h0666, 0, 8'h00,  1, 16'hFFFF, 15'h0000, 1};

        repeat (2) tick();
        chk("reset_outputs",
            {s_shk_wready, s_shk_smiso, s_shk_dmiso, m_shk_wvalid, m_shk_smosi, o_shk_err, o_err_cnt}, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 60; i++) begin
            v.smosi   = 16'($urandom);
            if ($urandom_range(0, 5) == 0) v.smosi[7:0] = 8'h00;
            v.dmosi   = 15'($urandom);
            v.delay   = $urandom_range(0, 19);
            v.r_smiso = 16'($urandom);
            v.r_dmiso = 15'($urandom);
            v.noise   = 1'($urandom_range(0, 1));
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // Held request must not re-issue.
        s_shk_wvalid = 1'b1; s_shk_smosi = 16'h0008; s_shk_dmosi = 15'h0123;
        nreq = 0; nresp = 0; prev = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (m_shk_wvalid != 8'h00 && !prev) nreq++;
            prev = (m_shk_wvalid != 8'h00);
            if (s_shk_wready) nresp++;
            m_shk_wready = m_shk_wvalid;
        end
        chk("held_requests", nreq, 1);
        chk("held_responses", nresp, 1);
        s_shk_wvalid = 1'b0; m_shk_wready = '0;
        tick(); tick();

        // Saturate the error counter with empty selects.
        for (int i = 0; i < 300; i++) begin
            v = tbl[2];
            v.smosi = {8'($urandom), 8'h00};
            run_txn(model(v), "sat");
        end
        chk("err_cnt_saturated", o_err_cnt, 8'd255);

        // Reset in the middle of SEND.
        s_shk_wvalid = 1'b1; s_shk_smosi = 16'h0020; s_shk_dmosi = 15'h0042;
        m_shk_wready = '0;
        repeat (3) tick();
        chk("pre_reset_wvalid", m_shk_wvalid, 8'h20);
        #2 rst = 1'b1;
        #1;
        chk("reset_drop_wvalid", m_shk_wvalid, 8'h00);
        chk("reset_err_cnt", o_err_cnt, 8'h00);
        s_shk_wvalid = 1'b0;
        nresp = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_shk_wready) nresp++;
        end
        chk("reset_no_wready", nresp, 0);
        @(negedge clk);
        rst = 1'b0;
        err_model = 0;
        tick();
        v = tbl[0];
        v.smosi = 16'h0020; v.delay = 2; v.r_smiso = 16'h6789; v.r_dmiso = 15'h0321;
        run_txn(model(v), "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
